// File: rtl/gsim_seq_ctrl.sv
// gsim_seq_ctrl: sequencer for the Gauss-Seidel solver. It loads b, issues one row update
// at a time, counts sweeps, stops on convergence or at the limit, then streams x out.
module gsim_seq_ctrl #(
    parameter int N     = 16,
    parameter int IDX_W = 4,
    parameter int IT_W  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IT_W-1:0]  iter_limit,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             b_we,
    output logic [IDX_W-1:0] b_waddr,
    output logic             dp_issue,
    output logic [IDX_W-1:0] dp_row,
    output logic             dp_zero_x,
    input  logic             dp_wb_valid,
    input  logic             dp_delta_small,
    output logic             x_rd_en,
    output logic [IDX_W-1:0] x_rd_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_row,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic [IT_W-1:0]  sweeps_used
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, OUT} state_t;
    state_t state, state_nx;
    logic [IT_W-1:0]  limit, sweep;
    logic [IDX_W-1:0] load_cnt, row;
    logic [IDX_W:0]   rd_cnt;
    logic             all_small, last_row, conv_now, limit_hit, hs;
    always_comb begin
        last_row  = row == IDX_W'(N - 1);
        conv_now  = all_small && dp_delta_small && sweep != '0;
        limit_hit = IT_W'(sweep + 1'b1) == limit;
        hs        = out_valid && out_ready;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = (b_we && load_cnt == IDX_W'(N - 1)) ? ISSUE : LOAD;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = !dp_wb_valid ? WAIT :
                                (last_row && (conv_now || limit_hit)) ? OUT : ISSUE;
            OUT:     state_nx = done ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end
    // rd_cnt has one extra bit so its MSB flags that all N rows have been read
    always_comb begin
        busy      = state != IDLE;
        b_ready   = state == LOAD;
        b_we      = b_ready && b_valid;
        b_waddr   = b_we ? load_cnt : '0;
        dp_issue  = state == ISSUE;
        dp_row    = dp_issue ? row : '0;
        dp_zero_x = (state == ISSUE || state == WAIT) && sweep == '0;
        x_rd_en   = state == OUT && !rd_cnt[IDX_W] && (!out_valid || out_ready);
        x_rd_row  = x_rd_en ? rd_cnt[IDX_W-1:0] : '0;
        done      = state == OUT && hs && out_last;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            limit       <= '0;
            sweep       <= '0;
            load_cnt    <= '0;
            row         <= '0;
            rd_cnt      <= '0;
            all_small   <= 1'b0;
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_last    <= 1'b0;
            converged   <= 1'b0;
            sweeps_used <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    limit       <= (iter_limit == '0) ? IT_W'(1) : iter_limit;
                    converged   <= 1'b0;
                    sweeps_used <= '0;
                    load_cnt    <= '0;
                    rd_cnt      <= '0;
                end
                LOAD: if (b_we) begin
                    load_cnt <= load_cnt + 1'b1;
                    if (load_cnt == IDX_W'(N - 1)) begin
                        row       <= '0;
                        sweep     <= '0;
                        all_small <= 1'b1;
                    end
                end
                WAIT: if (dp_wb_valid) begin
                    all_small <= all_small && dp_delta_small;
                    if (!last_row) row <= row + 1'b1;
                    else begin
                        sweeps_used <= sweep + 1'b1;
                        if (conv_now) converged <= 1'b1;
                        else if (!limit_hit) begin
                            sweep     <= sweep + 1'b1;
                            row       <= '0;
                            all_small <= 1'b1;
                        end
                    end
                end
                OUT: if (x_rd_en) begin
                    rd_cnt    <= rd_cnt + 1'b1;
                    out_valid <= 1'b1;
                    out_row   <= rd_cnt[IDX_W-1:0];
                    out_last  <= rd_cnt[IDX_W-1:0] == IDX_W'(N - 1);
                end else if (hs) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gsim_seq_ctrl.sv
// tb_gsim_seq_ctrl: directed solves with a datapath model of programmable latency and
// scoreboard queues for b writes, row issues and output words.
module tb_gsim_seq_ctrl;
    logic       clk = 0, reset = 1, start = 0, b_valid = 0, dp_wb_valid = 0, dp_delta_small = 0, out_ready = 1;
    logic [6:0] iter_limit = 0, sweeps_used;
    logic       b_ready, b_we, dp_issue, dp_zero_x, x_rd_en, out_valid, out_last, busy, done, converged;
    logic [3:0] b_waddr, dp_row, x_rd_row, out_row;
    int vecs = 0, errs = 0;
    int bq[$], rowq[$], outq[$];
    int issue_cnt = 0, hs_cnt = 0, done_cnt = 0, small_mode = 0, dp_lat = 1, cyc = 0;
    bit bp = 0, pend = 0;
    int cd = 0, psw = 0;
    logic [3:0] pat = 4'b1001;
    bit prev_rd = 0, prev_stall = 0, prev_last = 0;
    logic [3:0] prev_rd_row = 0, prev_row = 0;

    gsim_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .iter_limit(iter_limit),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_waddr(b_waddr),
        .dp_issue(dp_issue), .dp_row(dp_row), .dp_zero_x(dp_zero_x),
        .dp_wb_valid(dp_wb_valid), .dp_delta_small(dp_delta_small),
        .x_rd_en(x_rd_en), .x_rd_row(x_rd_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .busy(busy), .done(done),
        .converged(converged), .sweeps_used(sweeps_used)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, b_ready, b_we, b_waddr, dp_issue, dp_row, dp_zero_x, x_rd_en, x_rd_row,
                out_valid, out_row, out_last, done, converged, sweeps_used};
    endfunction

    // datapath model: one result dp_lat cycles after each issue
    always @(negedge clk) begin
        dp_wb_valid    = 0;
        dp_delta_small = 1'($urandom);
        if (reset) pend = 0;
        else begin
            if (pend) begin
                cd--;
                if (cd == 0) begin
                    pend = 0;
                    dp_wb_valid = 1;
                    dp_delta_small = small_mode == 1 ? psw >= 2 : small_mode == 2 ? psw == 0 : 1'b0;
                end
            end
            if (dp_issue) begin
                chk("one_outstanding", 64'(pend), 0);
                pend = 1;
                cd = dp_lat;
                psw = issue_cnt / 16;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        out_ready = bp ? pat[cyc % 4] : 1'b1;
    end

    always @(negedge clk) begin
        int e;
        #1;
        if (reset) begin
            prev_rd = 0;
            prev_stall = 0;
        end else begin
            if (b_we) begin
                e = bq.size() != 0 ? bq.pop_front() : -1;
                chk("b_waddr", 64'(b_waddr), 64'(e));
            end
            if (dp_issue) begin
                e = rowq.size() != 0 ? rowq.pop_front() : -1;
                chk("dp_row_zero_x", 64'({dp_zero_x, dp_row}), 64'(e));
                issue_cnt++;
            end
            if (prev_rd) chk("rd_to_valid", 64'({out_valid, out_row}), 64'({1'b1, prev_rd_row}));
            if (prev_stall) chk("stall_hold", 64'({out_valid, out_row, out_last}), 64'({1'b1, prev_row, prev_last}));
            if (out_valid && out_ready) begin
                e = outq.size() != 0 ? outq.pop_front() : -1;
                chk("out_word", 64'({out_last, out_row}), e == 15 ? 64'h1f : 64'(e));
                chk("done_on_last", 64'(done), 64'(e == 15));
                hs_cnt++;
            end
            if (done) done_cnt++;
            prev_rd = x_rd_en;
            prev_rd_row = x_rd_row;
            prev_stall = out_valid && !out_ready;
            prev_row = out_row;
            prev_last = out_last;
        end
    end

    task automatic load(input bit gaps, input bit pulse);
        int sent = 0, g = 0;
        while (sent < 16 && g < 1000) begin
            @(negedge clk);
            g++;
            b_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (pulse && sent == 5) begin
                start = 1;
                iter_limit = 1;
            end else start = 0;
            if (b_valid && b_ready) sent++;
        end
        chk("load_words", 64'(sent), 16);
        @(negedge clk);
        b_valid = 0;
        start = 0;
    endtask

    task automatic kick(input int lim, input int exp_sw);
        issue_cnt = 0;
        hs_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 16; i++) bq.push_back(i);
        for (int s = 0; s < exp_sw; s++)
            for (int r = 0; r < 16; r++) rowq.push_back(((s == 0) ? 16 : 0) + r);
        @(negedge clk);
        start = 1;
        iter_limit = 7'(lim);
        @(negedge clk);
        start = 0;
        iter_limit = 7'($urandom);
    endtask

    task automatic run(input int lim, input int mode, input int lat, input bit gaps, input bit bpr,
                       input bit pulse, input int exp_sw, input bit exp_conv);
        int g = 0;
        small_mode = mode;
        dp_lat = lat;
        bp = bpr;
        for (int i = 0; i < 16; i++) outq.push_back(i);
        kick(lim, exp_sw);
        load(gaps, pulse);
        while (done_cnt == 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", 64'(done_cnt != 0), 1);
        @(negedge clk);
        #2;
        chk("sweeps_used", 64'(sweeps_used), 64'(exp_sw));
        chk("converged", 64'(converged), 64'(exp_conv));
        chk("busy_after", 64'(busy), 0);
        chk("issue_count", 64'(issue_cnt), 64'(exp_sw * 16));
        chk("handshakes", 64'(hs_cnt), 16);
        chk("done_pulses", 64'(done_cnt), 1);
        chk("queues_empty", 64'(rowq.size() + bq.size() + outq.size()), 0);
        rowq.delete();
        bq.delete();
        outq.delete();
        bp = 0;
    endtask

    initial begin
        int g = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #2;
        chk("reset_outs", all_outs(), 0);
        run(3, 0, 1, 0, 0, 0, 3, 0);
        run(72, 1, 1, 0, 0, 0, 3, 1);
        run(5, 2, 1, 0, 0, 0, 5, 0);
        run(0, 0, 1, 0, 0, 0, 1, 0);
        run(2, 0, 1, 1, 1, 1, 2, 0);
        run(3, 0, 5, 0, 0, 0, 3, 0);
        small_mode = 0;
        dp_lat = 1;
        kick(3, 3);
        load(0, 0);
        while (issue_cnt < 24 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("abort_point", 64'(issue_cnt), 24);
        chk("abort_busy", 64'(busy), 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #2;
        chk("abort_outs", all_outs(), 0);
        rowq.delete();
        bq.delete();
        run(2, 0, 1, 0, 0, 0, 2, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
